// File: rtl/muldiv_seq_16_if.sv
// Start/result bundle for the sequential 16-bit multiply/divide unit.
// The master issues operations; the slave reports progress and results.
interface muldiv_seq_16_if;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        div0;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div0
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div0
  );
endinterface

// File: rtl/muldiv_seq_16.sv
// Sequential 16x16 shift-add multiply / 16/16 restoring divide.
// Optional macro MULDIV_DIV0_FAST_EN: divide-by-zero short-cuts to FIN.
module muldiv_seq_16 #(
  parameter int ITER = 16
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_seq_16_if.slave bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic          op_l;
  logic [15:0]   opd;
  logic [15:0]   acc_hi, acc_lo;
  logic [15:0]   res_lo, res_hi;
  logic          accept, last, fast;
  logic [16:0]   r_sh, cla_out;
  logic [15:0]   cla_a, cla_b;
  logic          cla_cin;
  logic [15:0]   hi_d, lo_d;

  assign accept = bus.start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(ITER - 1));

`ifdef MULDIV_DIV0_FAST_EN
  logic div0_r;

  assign fast = accept && bus.op && (bus.b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div0_r <= 1'b0;
    else if (accept) div0_r <= fast;
  end

  assign bus.div0 = (state == FIN) && div0_r;
`else
  assign fast     = 1'b0;
  assign bus.div0 = 1'b0;
`endif

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == FIN);
  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, FIN: state_d = accept ? (fast ? FIN : RUN) : IDLE;
      RUN:       if (last) state_d = FIN;
      default:   state_d = IDLE;
    endcase
  end

  // Divide: partial remainder shifted left with the next dividend bit.
  assign r_sh = {acc_hi, acc_lo[15]};

  always_comb begin
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;
    if (state == RUN) begin
      if (op_l) begin
        cla_a   = r_sh[15:0];
        cla_b   = ~opd;
        cla_cin = 1'b1;
      end else begin
        cla_a = acc_hi;
        cla_b = acc_lo[0] ? opd : '0;
      end
    end
  end

  assign cla_out = {1'b0, cla_a} + {1'b0, cla_b}
                 + {16'd0, cla_cin};

  // Carry-out of r' + ~b + 1 is exactly r'[15:0] >= b.
  always_comb begin
    hi_d = acc_hi;
    lo_d = acc_lo;
    if (op_l) begin
      lo_d = {acc_lo[14:0], cla_out[16] | r_sh[16]};
      hi_d = lo_d[0] ? cla_out[15:0] : r_sh[15:0];
    end else begin
      hi_d = cla_out[16:1];
      lo_d = {cla_out[0], acc_lo[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_l   <= 1'b0;
      opd    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      res_lo <= '0;
      res_hi <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_l   <= bus.op;
      opd    <= bus.op ? bus.b : bus.a;
      acc_hi <= '0;
      acc_lo <= bus.op ? bus.a : bus.b;
      if (fast) begin
        res_lo <= '1;
        res_hi <= bus.a;
      end
    end else if (state == RUN) begin
      cnt    <= cnt + 1'b1;
      acc_hi <= hi_d;
      acc_lo <= lo_d;
      if (last) begin
        res_lo <= lo_d;
        res_hi <= hi_d;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_16.sv
// Randomized bench for muldiv_seq_16 against an arithmetic reference.
// Honours MULDIV_DIV0_FAST_EN for divide-by-zero timing and div0.
module tb_muldiv_seq_16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] prev = '0;

  muldiv_seq_16_if bus ();

  muldiv_seq_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic o,
                                        input logic [15:0] x,
                                        input logic [15:0] y);
    int unsigned p;
    if (!o) begin
      p = x * y;
      return p;
    end
    if (y == 0) return {x, 16'hFFFF};
    return {16'(x % y), 16'(x / y)};
  endfunction

  function automatic bit is_fast(input logic o,
                                 input logic [15:0] y);
`ifdef MULDIV_DIV0_FAST_EN
    return o && (y == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic launch(input logic o,
                        input logic [15:0] x,
                        input logic [15:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  task automatic finish_op(input logic o,
                           input logic [15:0] x,
                           input logic [15:0] y);
    int k;
    logic [31:0] exp;
    bit f;
    exp = model(o, x, y);
    f   = is_fast(o, y);
    check("busy_after_start", bus.busy, !f);
    k = 0;
    while (!bus.done && k < 40) begin
      bus.start = (k == 4);
      if (k == 4) begin
        bus.op = 1'($urandom);
        bus.a  = 16'($urandom);
        bus.b  = 16'($urandom);
      end
      if (k == 8)
        check("hold_prev", {bus.result_hi, bus.result_lo}, prev);
      @(posedge clk);
      #1;
      k++;
    end
    bus.start = 1'b0;
    check("latency", k, f ? 0 : 16);
    check("result_lo", bus.result_lo, exp[15:0]);
    check("result_hi", bus.result_hi, exp[31:16]);
    check("div0", bus.div0, f);
    check("busy_at_done", bus.busy, 1'b0);
    prev = exp;
  endtask

  task automatic idle_chk();
    @(posedge clk);
    #1;
    check("done_pulse", {bus.done, bus.div0}, 2'b00);
  endtask

  task automatic run(input logic o,
                     input logic [15:0] x,
                     input logic [15:0] y);
    launch(o, x, y);
    finish_op(o, x, y);
    idle_chk();
  endtask

  initial begin
    int dn;
    logic o;
    logic [15:0] x, y;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {bus.busy, bus.done, bus.div0}, 3'b000);
    check("rst_res", {bus.result_hi, bus.result_lo}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(1'b0, 16'd3, 16'd5);
    run(1'b0, 16'hFFFF, 16'hFFFF);
    run(1'b1, 16'd100, 16'd7);
    run(1'b1, 16'h8000, 16'h0001);
    run(1'b1, 16'h1234, 16'h0000);

    // Back-to-back: start held through FIN.
    launch(1'b1, 16'd50000, 16'd123);
    finish_op(1'b1, 16'd50000, 16'd123);
    launch(1'b0, 16'hABCD, 16'h1357);
    check("b2b_busy", {bus.busy, bus.done}, 2'b10);
    check("b2b_hold", {bus.result_hi, bus.result_lo}, prev);
    finish_op(1'b0, 16'hABCD, 16'h1357);
    idle_chk();

    for (int i = 0; i < 30; i++) begin
      o = 1'($urandom);
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run(o, x, y);
    end

    // Reset in the middle of a multiply.
    launch(1'b0, 16'h7777, 16'h9999);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {bus.busy, bus.done, bus.div0}, 3'b000);
    check("mid_rst_res", {bus.result_hi, bus.result_lo}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev = '0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dn++;
    end
    check("no_done_after_rst", dn, 0);
    run(1'b0, 16'h1234, 16'h5678);
    run(1'b1, 16'hFFFF, 16'h0010);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_seq_16.md
Name: muldiv_seq_16

Overview:
- Multi-cycle unsigned 16x16 multiply and 16/16 divide unit in the execute stage of the 16-bit CPU.
- Sits directly upstream of the shared add/sub datapath (cla_16).
- Each iteration it drives cla_16 operands and the add/sub select, then consumes the sum/difference into its accumulator.
- Accepts one operation per start handshake and returns a 32-bit result pair.

Parameters:
- ITER, 16, iteration count per operation; equals the operand width and is fixed at 16 for this CPU.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when not busy.
- op  input  1  0 = multiply, 1 = divide; latched with start.
- a  input  16  multiplicand / dividend; latched with start.
- b  input  16  multiplier / divisor; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results update.
- result_lo  output  16  product[15:0] or quotient.
- result_hi  output  16  product[31:16] or remainder.
- div0  output  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state = IDLE. busy, done, div0, result_lo, result_hi, iteration counter and internal accumulators all 0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 at an edge latches op/a/b, clears the counter, and moves to RUN. busy=1 from the next cycle.
  - RUN: one iteration per edge, counter 0..15. After the edge where counter=15, move to FIN.
  - FIN: lasts one cycle. busy=0, done=1, result_lo/result_hi hold the new values. start=1 in FIN is accepted exactly as in IDLE and moves to RUN; otherwise move to IDLE.
- Latency: start edge T0, iteration edges T1..T16, done high in the cycle after T16. Back-to-back operations complete every 17 cycles.
- start while busy: ignored. Latched operands and op do not change.
- Result registers: written only on the FIN-entry edge. They hold until the next completion, including while the next operation runs.
- Multiply (shift-add, op=0):
  - 17-bit accumulator acc = {carry, hi}, plus multiplier register m.
  - Each iteration: if m[0] then sum = hi + a_latched via cla_16 with c_in=0, carry = (sum < hi). Otherwise sum = hi, carry = 0.
  - Then {carry, sum, m} shifts right by one into {hi, m}.
  - Final result: hi:m.
- Divide (restoring, op=1):
  - r (17-bit partial remainder), q (quotient).
  - Each iteration: r' = {r[15:0], q[15]}, q <<= 1.
  - Trial difference: r'[15:0] - b via cla_16 with c_in=1.
  - If r'[16]=1 or r'[15:0] >= b: r = difference zero-extended, q[0] = 1. Otherwise r = r', q[0] = 0.
  - Final result: lo = q, hi = r[15:0].
- cla_16 is idle (c_in=0, a=b=0) outside RUN.
- Reset mid-operation: aborts immediately. No done pulse, results return to 0.

Optional Feature:
- Macro: MULDIV_DIV0_FAST_EN
- Defined:
  - Divide with b=0 skips RUN and goes IDLE -> FIN in one edge (done 2 cycles after start instead of 17).
  - result_lo = 0xFFFF, result_hi = a; div0 = 1 for the done cycle only.
- Undefined:
  - Divide by zero runs all 16 iterations through the normal algorithm, which yields the same 0xFFFF / a values.
  - div0 is tied to 0.

Test Plan:
- Multiply: a=3, b=5 -> done exactly 17 cycles after start edge; result_hi=0x0000, result_lo=0x000F.
- Multiply: a=0xFFFF, b=0xFFFF -> result_hi=0xFFFE, result_lo=0x0001 (exercises carry into accumulator bit 16).
- Divide: a=100, b=7 -> result_lo=14, result_hi=2. Also a=0x8000, b=0x0001 -> result_lo=0x8000, result_hi=0.
- Divide: a=0x1234, b=0 -> result_lo=0xFFFF, result_hi=0x1234. With the macro: done at cycle 2 and div0=1. Without: done at cycle 17 and div0=0.
- Handshake:
  - start pulsed at cycle 5 during busy -> ignored, first result unchanged.
  - start held high through FIN -> second op accepted with no IDLE cycle.
  - Previous results stable until the second done.
- Reset: deassert rst_n at iteration 8 of a multiply -> outputs immediately 0 and no done. A fresh op after release completes correctly.
